// File: rtl/hsv_core_flush_ctrl.sv
// Flush initiator: broadcasts flush_req, gathers per-unit acks, sequences entry/exit and
// flags hung or misbehaving responders. Comes out of reset already flushing.
module hsv_core_flush_ctrl #(
  parameter int unsigned N_UNITS        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk_core,
  input  logic               rst_core_n,
  input  logic               start_valid_i,
  output logic               start_ready_o,
  output logic               flush_req,
  input  logic [N_UNITS-1:0] flush_ack,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [N_UNITS-1:0] stuck_mask_o,
  output logic               proto_err_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StEnter, StExit} state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               proto_q, proto_d;
  logic [N_UNITS-1:0] stuck_q, stuck_d;
  logic [N_UNITS-1:0] ack_prev_q;
  logic [CntW-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle:  if (start_valid_i) state_d = StEnter;
      StEnter: if (&flush_ack) state_d = StExit;
      StExit: begin
        if (~|flush_ack) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StEnter;
    endcase
    req_d = (state_d == StEnter);
  end

  // With TIMEOUT_CYCLES == 0 the counter sits at CntMax == 0 and never fires.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    stuck_d   = stuck_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != StIdle && cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_d == CntMax) begin
        timeout_d = 1'b1;
        if (!timeout_q) stuck_d = flush_ack ^ {N_UNITS{req_q}};
      end
    end
  end

  always_comb begin
    proto_d = proto_q;
    if (state_q == StIdle && |flush_ack) proto_d = 1'b1;
    // A rising ack during exit means a unit re-entered flush unprompted.
    if (state_q == StExit && |(flush_ack & ~ack_prev_q)) proto_d = 1'b1;
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q    <= StEnter;
      req_q      <= 1'b1;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      proto_q    <= 1'b0;
      stuck_q    <= '0;
      ack_prev_q <= '1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      proto_q    <= proto_d;
      stuck_q    <= stuck_d;
      ack_prev_q <= flush_ack;
      cnt_q      <= cnt_d;
    end
  end

  assign start_ready_o = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign flush_req     = req_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign stuck_mask_o  = stuck_q;
  assign proto_err_o   = proto_q;

endmodule
